cb_updown_cnt: RTL and testbench
================================

# cb_updown_cnt

Parametrised synchronous up/down counter register with direction control, carry-in/carry-out cascading, synchronous load, programmable modulus and optional saturation. It is the successor of the 2-bit combinational up/down carry slice: it adds the state register, extends to any width, and adds load, modulus and saturate behaviour. It sits in the counter and timer primitive set. Instances cascade through CI/CO to form wider or multi-stage counters.

## Interface
- WIDTH, 8: counter width in bits, 1..32.
- MODULUS, 0: count range. 0 means 2^WIDTH. Otherwise Q spans 0..MODULUS-1, with 2 <= MODULUS <= 2^WIDTH.
- SATURATE, 0: 0 = wrap at the terminal value; 1 = hold at the terminal value.
- RESET_VALUE, 0: value of Q after reset. Must be below the effective modulus.

Ports:
- CK  in  1  clock, rising-edge active.
- CDN  in  1  reset, asynchronous, active-low.
- SP  in  1  clock enable. When low, Q, LD and counting are all frozen.
- CI  in  1  carry/borrow-in. A count step occurs only when SP=1 and CI=1.
- CON  in  1  direction: 1 = up, 0 = down.
- LD  in  1  synchronous load, qualified by SP.
- D  in  WIDTH  load value.
- Q  out  WIDTH  registered count.
- CO  out  1  combinational carry/borrow-out for cascading.
- WRAP  out  1  registered one-cycle terminal-event pulse.

## Operation
- Let M be the effective modulus: MODULUS, or 2^WIDTH if MODULUS=0. Let TOP = M-1.
- The terminal value is TOP when CON=1 and 0 when CON=0.
- Action priority on each rising CK, when SP=1:
  1. LD=1: Q <= D if D < M; otherwise Q <= TOP. No count step occurs this cycle, even if CI=1. WRAP <= 0.
  2. Otherwise, if CI=1 and Q is not at the terminal value: Q <= Q+1 (up) or Q-1 (down). WRAP <= 0.
  3. Otherwise, if CI=1 and Q is at the terminal value:
     - SATURATE=0: Q <= 0 (up) or TOP (down).
     - SATURATE=1: Q holds.
     - In both modes WRAP <= 1.
  4. Otherwise (CI=0): Q holds, WRAP <= 0.
- When SP=0: Q holds and WRAP <= 0.
- CO = CI & (Q at terminal value for the current CON). It is purely combinational from Q, CI and CON, and independent of SP and LD.
  - For cascading, connect the low stage CO to the next stage CI, and tie CON and SP in common across stages.
- Arithmetic is modulo M. The value of Q is never outside 0..TOP.
- CON may change on any cycle. It takes effect on the next qualifying edge, and CO follows it immediately.

## Timing
- Reset: while CDN=0, Q = RESET_VALUE and WRAP = 0, immediately and independent of CK.
- CDN may assert mid-count. The deassertion of CDN is synchronised externally. The first count can occur on the first rising CK at which CDN=1.
- Latency:
  - Q updates one CK after the qualifying edge.
  - WRAP goes high in the same cycle that Q shows the wrapped or held value, and lasts exactly one cycle per terminal event.
  - WRAP stays high on consecutive cycles if terminal events repeat, for example saturated with CI held high.
  - CO has zero latency, combinational from the current Q.
- Simultaneous events:
  - LD with CI at the terminal value: load wins and WRAP = 0.
  - SP=0 masks LD.
- Single-cycle steady counting: one step per CK whenever SP=CI=1.

## Test plan
- Use WIDTH=4, MODULUS=10, SATURATE=0, RESET_VALUE=3 unless a case says otherwise.
- Reset and hold: CDN=0 applied mid-count at Q=7 -> Q=3 and WRAP=0 asynchronously, without waiting for CK. Then CDN=1, SP=CI=1, CON=1 for 8 edges -> Q goes 4,5..9,0,1. WRAP=1 only in the cycle Q=0.
- Down wrap and CO: load D=1, then CON=0, CI=1 -> Q goes 0,9,8. CO=1 only while Q=0. WRAP=1 in the cycle Q=9.
- Load clamp and priority:
  - Q=9, CON=1, CI=1, LD=1, D=12 -> Q=9, the clamp to TOP, and WRAP=0.
  - Next edge with LD=0 -> Q=0 and WRAP=1.
- Enable gating:
  - SP=0 with LD=1, D=5, CI=1 for 3 edges -> Q unchanged and WRAP=0.
  - CO still tracks Q, CI and CON during this time.
- Saturate mode (SATURATE=1):
  - Up from 8 with CI=1 for 4 edges -> Q goes 9,9,9,9, and WRAP is high on the 2nd, 3rd and 4th of those cycles.
  - Then CON=0 -> Q goes 8,7.
- Cascade:
  - Setup: two WIDTH=4, MODULUS=0 instances, with the low stage CO driving the high stage CI, both starting at 0.
  - Count up 300 edges -> the combined value is 300 mod 256 = 44. The high-stage WRAP fires once.
  - Switch CON=0 and count 45 edges -> the combined value is 255.

Source files
------------

// File: rtl/cb_updown_cnt.sv
// Cascadable up/down counter register with direction control, synchronous
// load, programmable modulus and optional saturation at the terminal value.
module cb_updown_cnt #(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned MODULUS     = 0,
  parameter bit              SATURATE    = 1'b0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             SP,
  input  logic             CI,
  input  logic             CON,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             WRAP
);

  // One extra bit so a full 2^WIDTH modulus is representable.
  localparam int unsigned     MW      = WIDTH + 1;
  localparam logic [MW-1:0]   MOD_EFF = (MODULUS == 0) ? (MW'(1) << WIDTH) : MW'(MODULUS);
  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MOD_EFF - MW'(1));
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VALUE);

  logic             at_term_c;
  logic             d_in_range_c;
  logic [WIDTH-1:0] q_next_c;
  logic             wrap_next_c;

  // Terminal value depends on the live direction, so CO follows CON at once.
  always_comb begin
    at_term_c    = CON ? (Q == TOP) : (Q == '0);
    d_in_range_c = ({1'b0, D} < MOD_EFF);
    q_next_c     = Q;
    wrap_next_c  = 1'b0;
    if (SP) begin
      if (LD) begin
        q_next_c = d_in_range_c ? D : TOP;
      end else if (CI) begin
        if (!at_term_c) begin
          q_next_c = CON ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
        end else begin
          wrap_next_c = 1'b1;
          if (!SATURATE) begin
            q_next_c = CON ? '0 : TOP;
          end
        end
      end
    end
  end

  assign CO = CI & at_term_c;

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      Q    <= RST_Q;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next_c;
      WRAP <= wrap_next_c;
    end
  end

endmodule

// File: tb/tb_cb_updown_cnt.sv
// Bench for cb_updown_cnt: directed steps from the test plan plus a random
// phase, all checked against an arithmetic reference model.
module tb_cb_updown_cnt;

  logic       CK;
  logic       cdn;
  logic       sp, ci, con, ld;
  logic [3:0] d;
  logic [3:0] q, q_sat;
  logic       co, co_sat, wrap, wrap_sat;

  logic       x_ci, x_con;
  logic [3:0] x_lo_q, x_hi_q;
  logic       x_lo_co, x_hi_co, x_lo_wrap, x_hi_wrap;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  int mq[2];
  int mw[2];
  int xc;
  int xw_lo, xw_hi;
  int hi_wraps;

  localparam int M  = 10;
  localparam int RV = 3;

  cb_updown_cnt #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VALUE(3)) dut (
    .CK(CK), .CDN(cdn), .SP(sp), .CI(ci), .CON(con), .LD(ld), .D(d),
    .Q(q), .CO(co), .WRAP(wrap));

  cb_updown_cnt #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VALUE(3)) dut_sat (
    .CK(CK), .CDN(cdn), .SP(sp), .CI(ci), .CON(con), .LD(ld), .D(d),
    .Q(q_sat), .CO(co_sat), .WRAP(wrap_sat));

  cb_updown_cnt #(.WIDTH(4), .MODULUS(0), .SATURATE(1'b0), .RESET_VALUE(0)) x_lo (
    .CK(CK), .CDN(cdn), .SP(1'b1), .CI(x_ci), .CON(x_con), .LD(1'b0), .D(4'd0),
    .Q(x_lo_q), .CO(x_lo_co), .WRAP(x_lo_wrap));

  cb_updown_cnt #(.WIDTH(4), .MODULUS(0), .SATURATE(1'b0), .RESET_VALUE(0)) x_hi (
    .CK(CK), .CDN(cdn), .SP(1'b1), .CI(x_lo_co), .CON(x_con), .LD(1'b0), .D(4'd0),
    .Q(x_hi_q), .CO(x_hi_co), .WRAP(x_hi_wrap));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int at_term(input int qv, input int m, input logic dir);
    return (dir ? (qv == m - 1) : (qv == 0)) ? 1 : 0;
  endfunction

  // One qualifying edge of a single-stage counter, from the rules in plain arithmetic.
  task automatic model_step(input bit sat, inout int qv, inout int wv);
    wv = 0;
    if (sp) begin
      if (ld) begin
        qv = (int'(d) < M) ? int'(d) : M - 1;
      end else if (ci) begin
        wv = at_term(qv, M, con);
        if (!(sat && wv == 1))
          qv = (qv + (con ? 1 : M - 1)) % M;
      end
    end
  endtask

  task automatic check_all();
    chk("q", q, mq[0]);
    chk("wrap", wrap, mw[0]);
    chk("co", co, (ci && at_term(mq[0], M, con) == 1) ? 1 : 0);
    chk("q_sat", q_sat, mq[1]);
    chk("wrap_sat", wrap_sat, mw[1]);
    chk("co_sat", co_sat, (ci && at_term(mq[1], M, con) == 1) ? 1 : 0);
    chk("x_lo_q", x_lo_q, xc % 16);
    chk("x_hi_q", x_hi_q, xc / 16);
    chk("x_lo_wrap", x_lo_wrap, xw_lo);
    chk("x_hi_wrap", x_hi_wrap, xw_hi);
    chk("x_lo_co", x_lo_co, (x_ci && at_term(xc % 16, 16, x_con) == 1) ? 1 : 0);
    chk("x_hi_co", x_hi_co,
        (x_ci && at_term(xc % 16, 16, x_con) == 1 && at_term(xc / 16, 16, x_con) == 1) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge CK);
    model_step(1'b0, mq[0], mw[0]);
    model_step(1'b1, mq[1], mw[1]);
    // Cascade viewed as one 8-bit counter.
    xw_lo = 0;
    xw_hi = 0;
    if (x_ci) begin
      xw_lo = at_term(xc % 16, 16, x_con);
      xw_hi = (x_con ? (xc == 255) : (xc == 0)) ? 1 : 0;
      xc = (xc + (x_con ? 1 : 255)) % 256;
    end
    if (xw_hi == 1) hi_wraps++;
    #1;
    check_all();
  endtask

  // Mid-cycle reset pulse; outputs must clear without any clock edge.
  task automatic reset_pulse();
    #2;
    cdn = 1'b0;
    mq[0] = RV; mq[1] = RV; mw[0] = 0; mw[1] = 0;
    xc = 0; xw_lo = 0; xw_hi = 0;
    #1;
    chk("async_rst_q", q, RV);
    chk("async_rst_wrap", wrap, 0);
    check_all();
    cdn = 1'b1;
  endtask

  initial begin
    int exp_up[8];
    exp_up = '{4, 5, 6, 7, 8, 9, 0, 1};
    cdn = 1'b0; sp = 1'b0; ci = 1'b0; con = 1'b1; ld = 1'b0; d = 4'd0;
    x_ci = 1'b0; x_con = 1'b1;
    mq[0] = RV; mq[1] = RV; mw[0] = 0; mw[1] = 0;
    xc = 0; xw_lo = 0; xw_hi = 0; hi_wraps = 0;

    #12;
    chk("reset_q", q, RV);
    chk("reset_wrap", wrap, 0);
    check_all();
    cdn = 1'b1;

    // Count to 7, then reset mid-count.
    sp = 1'b1; ci = 1'b1; con = 1'b1;
    repeat (4) tick();
    chk("pre_reset_q", q, 7);
    reset_pulse();

    for (int i = 0; i < 8; i++) begin
      tick();
      chk("up_seq_q", q, exp_up[i]);
      chk("up_seq_wrap", wrap, (i == 6) ? 1 : 0);
    end

    // Down wrap and CO.
    ld = 1'b1; d = 4'd1;
    tick();
    chk("load1_q", q, 1);
    ld = 1'b0; con = 1'b0;
    tick();
    chk("down_q0", q, 0);
    chk("down_co0", co, 1);
    tick();
    chk("down_q9", q, 9);
    chk("down_wrap9", wrap, 1);
    chk("down_co9", co, 0);
    tick();
    chk("down_q8", q, 8);
    chk("down_wrap8", wrap, 0);

    // Load clamp and priority over a terminal count.
    ld = 1'b1; d = 4'd9;
    tick();
    chk("load9_q", q, 9);
    d = 4'd12; con = 1'b1; ci = 1'b1;
    tick();
    chk("clamp_q", q, 9);
    chk("clamp_wrap", wrap, 0);
    ld = 1'b0;
    tick();
    chk("after_clamp_q", q, 0);
    chk("after_clamp_wrap", wrap, 1);

    // Enable gating: LD and counting frozen, CO still live.
    sp = 1'b0; ld = 1'b1; d = 4'd5; ci = 1'b1;
    for (int i = 0; i < 3; i++) begin
      con = i[0];
      tick();
      chk("gated_q", q, 0);
      chk("gated_wrap", wrap, 0);
      chk("gated_co", co, (con == 1'b0) ? 1 : 0);
      con = ~con;
      #1;
      chk("gated_co_flip", co, (con == 1'b0) ? 1 : 0);
      check_all();
    end

    // Saturating behaviour.
    sp = 1'b1; ld = 1'b1; d = 4'd8; ci = 1'b0; con = 1'b1;
    tick();
    chk("sat_load_q", q_sat, 8);
    ld = 1'b0; ci = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_hold_q", q_sat, 9);
      chk("sat_hold_wrap", wrap_sat, (i > 0) ? 1 : 0);
    end
    con = 1'b0;
    tick();
    chk("sat_down_q8", q_sat, 8);
    tick();
    chk("sat_down_q7", q_sat, 7);

    // Random phase.
    for (int i = 0; i < 250; i++) begin
      sp  = ($urandom_range(0, 7) != 0);
      ci  = ($urandom_range(0, 3) != 0);
      con = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 9) == 0);
      d   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) reset_pulse();
      tick();
    end

    // Cascade of two 4-bit stages.
    sp = 1'b0; ld = 1'b0; ci = 1'b0;
    reset_pulse();
    hi_wraps = 0;
    x_ci = 1'b1; x_con = 1'b1;
    repeat (300) tick();
    chk("cascade_up_value", {24'd0, x_hi_q, x_lo_q}, 44);
    chk("cascade_hi_wraps", hi_wraps, 1);
    x_con = 1'b0;
    repeat (45) tick();
    chk("cascade_down_value", {24'd0, x_hi_q, x_lo_q}, 255);
    x_ci = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
